// File: rtl/mac_pkg.sv
// Shared MAC-array types and helpers; drainer additions: requant function, cfg struct and FSM states.
// Build option: MAC_DRAIN_RELU_EN clamps the requantized lower bound to 0 instead of -128.
package mac_pkg;

  localparam int unsigned DRN_W_OUT      = 8;
  localparam int unsigned DRN_FIFO_DEPTH = 2;
  localparam int unsigned DRN_W_LANE     = 64;
  localparam int unsigned DRN_W_SHIFT    = 6;
  localparam int unsigned DRN_W_BEATS    = 16;

  typedef struct packed {
    logic [DRN_W_SHIFT-1:0] shift;
    logic [DRN_W_BEATS-1:0] beats;
  } drn_cfg_t;

  typedef enum logic [1:0] {DRN_IDLE, DRN_CFG, DRN_RUN, DRN_DRAIN} drn_state_e;

  // Round-half-up arithmetic shift then saturate; one guard bit keeps the rounding add exact.
  function automatic logic [DRN_W_OUT-1:0] drn_requant(input logic signed [DRN_W_LANE-1:0] x,
                                                       input logic [DRN_W_SHIFT-1:0]       s);
    logic signed [DRN_W_LANE:0] xe;
    logic signed [DRN_W_LANE:0] rnd;
    logic signed [DRN_W_LANE:0] y;
    logic [DRN_W_OUT-1:0]       q;
    xe  = {x[DRN_W_LANE-1], x};
    rnd = '0;
    if (s == '0) begin
      y = xe;
    end else begin
      rnd[s - 1'b1] = 1'b1;
      y = (xe + rnd) >>> s;
    end
    if (!y[DRN_W_LANE] && (|y[DRN_W_LANE-1:DRN_W_OUT-1])) begin
      q = 8'h7f;
`ifdef MAC_DRAIN_RELU_EN
    end else if (y[DRN_W_LANE]) begin
      q = 8'h00;
`else
    end else if (y[DRN_W_LANE] && !(&y[DRN_W_LANE-1:DRN_W_OUT-1])) begin
      q = 8'h80;
`endif
    end else begin
      q = y[DRN_W_OUT-1:0];
    end
    return q;
  endfunction

endpackage

// File: rtl/mac_drain_fifo.sv
// Two-entry ready/valid FIFO of {data, last} with registered head; occupancy exported for credits.
module mac_drain_fifo #(
  parameter int unsigned W_DATA = 512
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              push_valid,
  input  logic [W_DATA-1:0] push_data,
  input  logic              push_last,
  input  logic              pop_ready,
  output logic              pop_valid,
  output logic [W_DATA-1:0] pop_data,
  output logic              pop_last,
  output logic [1:0]        count
);

  logic [W_DATA:0] head_q;
  logic [W_DATA:0] tail_q;
  logic [1:0]      count_q;
  logic            pop;

  assign pop       = (count_q != 2'd0) && pop_ready;
  assign pop_valid = (count_q != 2'd0);
  assign pop_data  = head_q[W_DATA-1:0];
  assign pop_last  = head_q[W_DATA];
  assign count     = count_q;

  // Pushes only arrive with upstream credit, so a push never finds both slots busy.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push_valid, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= {push_last, push_data};
          else                 tail_q <= {push_last, push_data};
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= {push_last, push_data};
          end else begin
            head_q <= tail_q;
            tail_q <= {push_last, push_data};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mac_ofm_drainer.sv
// OFM drainer: requantizes MAC lane sums to int8, buffers them and streams them to TX.
// Build option: MAC_DRAIN_RELU_EN (ReLU-fused lower bound, see mac_pkg).
module mac_ofm_drainer
  import mac_pkg::*;
#(
  parameter int unsigned LANES   = 64,
  parameter int unsigned W_LANE  = DRN_W_LANE,
  parameter int unsigned W_SHIFT = DRN_W_SHIFT,
  parameter int unsigned W_BEATS = DRN_W_BEATS
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      drn_i_start,
  output logic                      drn_o_cfg_ready,
  input  logic                      drn_i_cfg_valid,
  input  logic [W_SHIFT-1:0]        drn_i_cfg_shift,
  input  logic [W_BEATS-1:0]        drn_i_cfg_beats,
  output logic                      drn_o_ofm_ready,
  input  logic                      drn_i_ofm_valid,
  input  logic [LANES*W_LANE-1:0]   drn_i_ofm_data,
  input  logic                      drn_i_ofm_last,
  input  logic                      drn_i_tx_ready,
  output logic                      drn_o_tx_valid,
  output logic [LANES*DRN_W_OUT-1:0] drn_o_tx_data,
  output logic                      drn_o_tx_last,
  output logic                      drn_o_done,
  output logic                      drn_o_err_len
);

  localparam int unsigned W_TX = LANES * DRN_W_OUT;

  drn_state_e       state_q;
  drn_cfg_t         cfg_q;
  logic [W_BEATS-1:0] cnt_q;
  logic             err_q;
  logic             done_q;
  logic             pipe_valid_q;
  logic             pipe_last_q;
  logic [W_TX-1:0]  pipe_data_q;
  logic [W_TX-1:0]  rq_data;
  logic [1:0]       fifo_count;
  logic             ofm_fire;
  logic             tx_fire;
  logic             at_final;
  logic             early_last;
  logic             forced_last;
  logic             beat_last;

  // Credit: at most two beats in flight across pipe register and FIFO.
  assign drn_o_ofm_ready = (state_q == DRN_RUN) && (({1'b0, pipe_valid_q} + fifo_count) < 2'd2);
  assign drn_o_cfg_ready = (state_q == DRN_CFG);
  assign drn_o_done      = done_q;
  assign drn_o_err_len   = err_q;

  assign ofm_fire    = drn_o_ofm_ready && drn_i_ofm_valid;
  assign tx_fire     = drn_o_tx_valid && drn_i_tx_ready;
  assign at_final    = (cfg_q.beats != '0) && (cnt_q == cfg_q.beats - 1'b1);
  assign early_last  = (cfg_q.beats != '0) && drn_i_ofm_last && !at_final;
  assign forced_last = at_final && !drn_i_ofm_last;
  assign beat_last   = drn_i_ofm_last || at_final;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [W_LANE-1:0] lane;
    assign lane = drn_i_ofm_data[i*W_LANE +: W_LANE];
    assign rq_data[i*DRN_W_OUT +: DRN_W_OUT] = drn_requant(lane, cfg_q.shift);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= DRN_IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DRN_IDLE: begin
          if (drn_i_start) begin
            state_q <= DRN_CFG;
            err_q   <= 1'b0;
          end
        end
        DRN_CFG: begin
          if (drn_i_cfg_valid) begin
            cfg_q.shift <= drn_i_cfg_shift;
            cfg_q.beats <= drn_i_cfg_beats;
            cnt_q       <= '0;
            state_q     <= DRN_RUN;
          end
        end
        DRN_RUN: begin
          if (ofm_fire) begin
            cnt_q <= cnt_q + 1'b1;
            if (early_last || forced_last) err_q <= 1'b1;
            if (beat_last) state_q <= DRN_DRAIN;
          end
        end
        DRN_DRAIN: begin
          if (tx_fire && drn_o_tx_last) begin
            state_q <= DRN_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= DRN_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pipe_valid_q <= 1'b0;
      pipe_last_q  <= 1'b0;
      pipe_data_q  <= '0;
    end else begin
      pipe_valid_q <= ofm_fire;
      if (ofm_fire) begin
        pipe_data_q <= rq_data;
        pipe_last_q <= beat_last;
      end
    end
  end

  mac_drain_fifo #(
    .W_DATA (W_TX)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .push_valid (pipe_valid_q),
    .push_data  (pipe_data_q),
    .push_last  (pipe_last_q),
    .pop_ready  (drn_i_tx_ready),
    .pop_valid  (drn_o_tx_valid),
    .pop_data   (drn_o_tx_data),
    .pop_last   (drn_o_tx_last),
    .count      (fifo_count)
  );

endmodule
